// File: rtl/irq_controller_pkg.sv
// Shared register map, claim-word layout and helpers for the interrupt controller.
// Optional overflow tracking is enabled by defining IRQ_OVERFLOW_EN.
package irq_controller_pkg;

  localparam int IRQ_ID_W            = 5;
  localparam int IRQ_CLAIM_VALID_BIT = 31;

  typedef enum logic [2:0] {
    IRQ_REG_PENDING  = 3'd0,
    IRQ_REG_ENABLE   = 3'd1,
    IRQ_REG_CLAIM    = 3'd2,
    IRQ_REG_ACTIVE   = 3'd3,
    IRQ_REG_OVERFLOW = 3'd4
  } irq_reg_e;

  // Word returned by a CLAIM read: valid flag in bit 31, source id in the low bits.
  function automatic logic [31:0] claim_word(input logic found, input logic [IRQ_ID_W-1:0] id);
    logic [31:0] w;
    w = 32'd0;
    if (found) begin
      w[IRQ_CLAIM_VALID_BIT] = 1'b1;
      w[IRQ_ID_W-1:0]        = id;
    end else begin
      w = 32'd0;
    end
    return w;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Word-addressed MMIO bus between the CPU (master) and the interrupt controller (slave).
interface irq_controller_if;

  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        rvalid;

  modport master (output a, output d, output we, output rd, input spo, input rvalid);
  modport slave  (input a, input d, input we, input rd, output spo, output rvalid);

endinterface

// File: rtl/irq_controller_prio_enc.sv
// Combinational priority encoder: lowest-index set request bit wins.
module irq_prio_enc
  import irq_controller_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0]     req,
  output logic                found,
  output logic [IRQ_ID_W-1:0] id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    found = |req;
    id    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      id = req[i] ? IRQ_ID_W'(i) : id;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge capture, pending/enable/active masks, claim/complete over MMIO, level irq.
// Define IRQ_OVERFLOW_EN to add sticky per-source overflow flags at register 4.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  irq_controller_if.slave bus
);

  localparam int PAD_W = 32 - NSRC;

  logic [NSRC-1:0]     src_q_r;
  logic [NSRC-1:0]     pending_r;
  logic [NSRC-1:0]     enable_r;
  logic [NSRC-1:0]     active_r;
  logic                irq_r;
  logic [31:0]         spo_r;
  logic                rvalid_r;

  logic [NSRC-1:0]     rise_s;
  logic [NSRC-1:0]     eligible_s;
  logic [NSRC-1:0]     claim_mask_s;
  logic [NSRC-1:0]     complete_mask_s;
  logic [NSRC-1:0]     pending_nxt_s;
  logic [NSRC-1:0]     active_nxt_s;
  logic [NSRC-1:0]     enable_nxt_s;
  logic                found_s;
  logic [IRQ_ID_W-1:0] id_s;
  logic                rd_ok_s;
  logic                claim_s;
  logic [31:0]         rdata_s;
  logic [31:0]         ovf_rdata_s;
  logic                unused_d_s;

  assign unused_d_s = ^bus.d;

  assign rise_s     = src & ~src_q_r;
  assign eligible_s = pending_r & enable_r & ~active_r;

  irq_prio_enc #(.NSRC(NSRC)) u_prio_enc (
    .req   (eligible_s),
    .found (found_s),
    .id    (id_s)
  );

  // A write in the same cycle as a read wins; the read is dropped entirely.
  always_comb begin
    rd_ok_s = bus.rd & ~bus.we;
    claim_s = rd_ok_s & (bus.a == IRQ_REG_CLAIM) & found_s;
  end

  // One-hot masks for the claimed id and for a COMPLETE write; out-of-range ids match nothing.
  always_comb begin
    claim_mask_s    = '0;
    complete_mask_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_mask_s[i]    = claim_s & (id_s == IRQ_ID_W'(i));
      complete_mask_s[i] = bus.we & (bus.a == IRQ_REG_CLAIM)
                           & (bus.d[IRQ_ID_W-1:0] == IRQ_ID_W'(i));
    end
  end

  // Next-state for the mask registers; a new edge beats a same-cycle claim clear.
  always_comb begin
    pending_nxt_s = (pending_r & ~claim_mask_s) | rise_s;
    active_nxt_s  = (active_r & ~complete_mask_s) | claim_mask_s;
    if (bus.we && (bus.a == IRQ_REG_ENABLE)) begin
      enable_nxt_s = bus.d[NSRC-1:0];
    end else begin
      enable_nxt_s = enable_r;
    end
  end

`ifdef IRQ_OVERFLOW_EN
  logic [NSRC-1:0] overflow_r;
  logic [NSRC-1:0] ovf_clr_s;
  logic [NSRC-1:0] overflow_nxt_s;

  // W1C clear, with a simultaneous new overflow taking priority.
  always_comb begin
    if (bus.we && (bus.a == IRQ_REG_OVERFLOW)) begin
      ovf_clr_s = bus.d[NSRC-1:0];
    end else begin
      ovf_clr_s = '0;
    end
    overflow_nxt_s = (overflow_r & ~ovf_clr_s) | (rise_s & pending_r);
  end

  // Sticky overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= '0;
    end else begin
      overflow_r <= overflow_nxt_s;
    end
  end

  assign ovf_rdata_s = {{PAD_W{1'b0}}, overflow_r};
`else
  assign ovf_rdata_s = 32'd0;
`endif

  // Read data multiplexer.
  always_comb begin
    rdata_s = 32'd0;
    case (bus.a)
      IRQ_REG_PENDING:  rdata_s = {{PAD_W{1'b0}}, pending_r};
      IRQ_REG_ENABLE:   rdata_s = {{PAD_W{1'b0}}, enable_r};
      IRQ_REG_CLAIM:    rdata_s = claim_word(found_s, id_s);
      IRQ_REG_ACTIVE:   rdata_s = {{PAD_W{1'b0}}, active_r};
      IRQ_REG_OVERFLOW: rdata_s = ovf_rdata_s;
      default:          rdata_s = 32'd0;
    endcase
  end

  // Source history, mask registers and the registered irq level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q_r   <= '0;
      pending_r <= '0;
      enable_r  <= '0;
      active_r  <= '0;
      irq_r     <= 1'b0;
    end else begin
      src_q_r   <= src;
      pending_r <= pending_nxt_s;
      enable_r  <= enable_nxt_s;
      active_r  <= active_nxt_s;
      irq_r     <= |eligible_s;
    end
  end

  // Registered read port; spo holds between reads, rvalid pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spo_r    <= 32'd0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= rd_ok_s;
      if (rd_ok_s) begin
        spo_r <= rdata_s;
      end else begin
        spo_r <= spo_r;
      end
    end
  end

  assign irq        = irq_r;
  assign bus.spo    = spo_r;
  assign bus.rvalid = rvalid_r;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (overflow expectations follow IRQ_OVERFLOW_EN).
module tb_irq_controller;
  import irq_controller_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] src;
  logic       irq;
  int         n_assert;
  int         n_fail;
  logic [31:0] rdv;
  logic [31:0] exp_ovf;

  irq_controller_if bus ();

  irq_controller #(.NSRC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .src   (src),
    .irq   (irq),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reg_read(input logic [2:0] addr, output logic [31:0] data);
    bus.a  = addr;
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check("rvalid_pulse", {31'd0, bus.rvalid}, 32'd1);
    data = bus.spo;
  endtask

  task automatic read_expect(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    reg_read(addr, v);
    check(tag, v, exp);
  endtask

  task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
    bus.a  = addr;
    bus.d  = data;
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    src = v;
    tick();
    src = 8'h00;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
`ifdef IRQ_OVERFLOW_EN
    exp_ovf = 32'h0000_0010;
`else
    exp_ovf = 32'h0000_0000;
`endif
    rst_n  = 1'b0;
    src    = 8'h00;
    bus.a  = 3'd0;
    bus.d  = 32'd0;
    bus.we = 1'b0;
    bus.rd = 1'b0;
    tick();
    tick();
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("reset_spo", bus.spo, 32'd0);
    rst_n = 1'b1;
    tick();
    read_expect("reset_pending", IRQ_REG_PENDING, 32'd0);
    read_expect("reset_enable", IRQ_REG_ENABLE, 32'd0);
    tick();
    check("rvalid_single", {31'd0, bus.rvalid}, 32'd0);

    // Timer pulse on source 0
    reg_write(IRQ_REG_ENABLE, 32'h0000_0001);
    pulse(8'h01);
    check("timer_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("timer_irq_high", {31'd0, irq}, 32'd1);
    read_expect("timer_pending", IRQ_REG_PENDING, 32'h0000_0001);
    read_expect("timer_claim", IRQ_REG_CLAIM, 32'h8000_0000);
    tick();
    check("timer_irq_low", {31'd0, irq}, 32'd0);
    read_expect("timer_active", IRQ_REG_ACTIVE, 32'h0000_0001);
    reg_write(IRQ_REG_CLAIM, 32'd0);
    read_expect("timer_active_done", IRQ_REG_ACTIVE, 32'd0);

    // Priority between sources 3 and 5
    reg_write(IRQ_REG_ENABLE, 32'h0000_00FF);
    pulse(8'h28);
    read_expect("prio_claim3", IRQ_REG_CLAIM, 32'h8000_0003);
    read_expect("prio_claim5", IRQ_REG_CLAIM, 32'h8000_0005);
    read_expect("prio_claim_none", IRQ_REG_CLAIM, 32'h0000_0000);
    read_expect("prio_active", IRQ_REG_ACTIVE, 32'h0000_0028);
    reg_write(IRQ_REG_CLAIM, 32'd3);
    reg_write(IRQ_REG_CLAIM, 32'd5);
    read_expect("prio_active_done", IRQ_REG_ACTIVE, 32'd0);
    check("prio_irq_idle", {31'd0, irq}, 32'd0);

    // Masked source latches pending
    reg_write(IRQ_REG_ENABLE, 32'd0);
    pulse(8'h04);
    read_expect("mask_pending", IRQ_REG_PENDING, 32'h0000_0004);
    tick();
    check("mask_irq_off", {31'd0, irq}, 32'd0);
    reg_write(IRQ_REG_ENABLE, 32'h0000_0004);
    check("mask_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("mask_irq_on", {31'd0, irq}, 32'd1);
    read_expect("mask_claim", IRQ_REG_CLAIM, 32'h8000_0002);
    reg_write(IRQ_REG_CLAIM, 32'd2);

    // Re-pend while active
    reg_write(IRQ_REG_ENABLE, 32'h0000_00FF);
    pulse(8'h02);
    read_expect("repend_claim", IRQ_REG_CLAIM, 32'h8000_0001);
    pulse(8'h02);
    read_expect("repend_pending", IRQ_REG_PENDING, 32'h0000_0002);
    check("repend_irq_off", {31'd0, irq}, 32'd0);
    read_expect("repend_no_nest", IRQ_REG_CLAIM, 32'h0000_0000);
    reg_write(IRQ_REG_CLAIM, 32'd7);
    read_expect("complete_inactive", IRQ_REG_ACTIVE, 32'h0000_0002);
    reg_write(IRQ_REG_CLAIM, 32'd1);
    check("repend_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("repend_irq_on", {31'd0, irq}, 32'd1);
    read_expect("repend_claim2", IRQ_REG_CLAIM, 32'h8000_0001);
    reg_write(IRQ_REG_CLAIM, 32'd1);

    // Read and write together: write performed, read dropped, spo held
    read_expect("rdwe_pre", IRQ_REG_ENABLE, 32'h0000_00FF);
    bus.a  = IRQ_REG_ENABLE;
    bus.d  = 32'h0000_000F;
    bus.we = 1'b1;
    bus.rd = 1'b1;
    tick();
    bus.we = 1'b0;
    bus.rd = 1'b0;
    check("rdwe_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rdwe_spo_hold", bus.spo, 32'h0000_00FF);
    read_expect("rdwe_enable", IRQ_REG_ENABLE, 32'h0000_000F);
    reg_write(IRQ_REG_ENABLE, 32'h0000_00FF);

    // Edge on a source in the same cycle it is claimed
    pulse(8'h40);
    tick();
    src    = 8'h40;
    bus.a  = IRQ_REG_CLAIM;
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    src    = 8'h00;
    check("samecyc_rvalid", {31'd0, bus.rvalid}, 32'd1);
    check("samecyc_claim", bus.spo, 32'h8000_0006);
    read_expect("samecyc_pending", IRQ_REG_PENDING, 32'h0000_0040);
    read_expect("samecyc_active", IRQ_REG_ACTIVE, 32'h0000_0040);
    reg_write(IRQ_REG_CLAIM, 32'd6);
    read_expect("samecyc_reclaim", IRQ_REG_CLAIM, 32'h8000_0006);
    reg_write(IRQ_REG_CLAIM, 32'd6);
    tick();
    tick();
    check("samecyc_irq_idle", {31'd0, irq}, 32'd0);

    // Overflow on a doubly-pended source
    pulse(8'h10);
    tick();
    pulse(8'h10);
    read_expect("ovf_read", IRQ_REG_OVERFLOW, exp_ovf);
    read_expect("ovf_pending", IRQ_REG_PENDING, 32'h0000_0010);
    reg_write(IRQ_REG_OVERFLOW, 32'h0000_0010);
    read_expect("ovf_cleared", IRQ_REG_OVERFLOW, 32'd0);
    read_expect("ovf_claim", IRQ_REG_CLAIM, 32'h8000_0004);
    reg_write(IRQ_REG_CLAIM, 32'd4);
    reg_write(3'd7, 32'hFFFF_FFFF);
    read_expect("unmapped_read", 3'd5, 32'd0);
    read_expect("unmapped_write", IRQ_REG_ENABLE, 32'h0000_00FF);

    // Asynchronous reset with a read in flight
    pulse(8'h03);
    read_expect("rst_pre_claim", IRQ_REG_CLAIM, 32'h8000_0000);
    tick();
    check("rst_pre_irq", {31'd0, irq}, 32'd1);
    bus.a  = IRQ_REG_PENDING;
    bus.rd = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_spo", bus.spo, 32'd0);
    tick();
    bus.rd = 1'b0;
    check("rst_rvalid_held", {31'd0, bus.rvalid}, 32'd0);
    rst_n = 1'b1;
    tick();
    read_expect("rst_pending", IRQ_REG_PENDING, 32'd0);
    read_expect("rst_active", IRQ_REG_ACTIVE, 32'd0);
    read_expect("rst_enable", IRQ_REG_ENABLE, 32'd0);
    read_expect("rst_ovf", IRQ_REG_OVERFLOW, 32'd0);
    check("rst_irq_after", {31'd0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
